// File: rtl/tcb_peri_gpio_arb.sv
// ============================================================================
// tcb_peri_gpio_arb
//
// Round-robin arbiter that lets several system managers (CPU, DMA, debug)
// share the register interface of one GPIO controller. Each requester gets a
// valid/ready request channel and a registered one-cycle response. A requester
// can hold a lock so that read-modify-write sequences on the GPIO output and
// enable registers are atomic. A lock timeout frees the interface if the lock
// owner stops issuing transfers.
//
// Parameters:
//   REQ_NUM  number of requesters (1..8)
//   SYS_DAT  register data width
//   SYS_ADR  register word address width
//   LCK_TMO  idle cycles a lock may last without an owner transfer (0 = never)
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   req_vld    per-requester request valid
//   req_rdy    per-requester request ready (the grant)
//   req_wen    per-requester direction, 1 = write, 0 = read
//   req_lck    per-requester lock request, keeps the grant after this transfer
//   req_adr    packed addresses, requester i at [i*SYS_ADR +: SYS_ADR]
//   req_wdt    packed write data, requester i at [i*SYS_DAT +: SYS_DAT]
//   rsp_vld    per-requester one-cycle response pulse
//   rsp_rdt    shared read data, qualified by rsp_vld
//   sys_wen    GPIO write enable, sys_wad/sys_wdt write address and data
//   sys_ren    GPIO read enable, sys_rad read address
//   sys_rdt    GPIO read data, valid in the same cycle as sys_ren
//   lck_tmo    one-cycle pulse when a lock has been released by timeout
// ============================================================================
module tcb_peri_gpio_arb #(
    parameter int unsigned REQ_NUM = 2,
    parameter int unsigned SYS_DAT = 32,
    parameter int unsigned SYS_ADR = 3,
    parameter int unsigned LCK_TMO = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_NUM-1:0]         req_vld,
    output logic [REQ_NUM-1:0]         req_rdy,
    input  logic [REQ_NUM-1:0]         req_wen,
    input  logic [REQ_NUM-1:0]         req_lck,
    input  logic [REQ_NUM*SYS_ADR-1:0] req_adr,
    input  logic [REQ_NUM*SYS_DAT-1:0] req_wdt,
    output logic [REQ_NUM-1:0]         rsp_vld,
    output logic [SYS_DAT-1:0]         rsp_rdt,
    output logic                       sys_wen,
    output logic [SYS_ADR-1:0]         sys_wad,
    output logic [SYS_DAT-1:0]         sys_wdt,
    output logic                       sys_ren,
    output logic [SYS_ADR-1:0]         sys_rad,
    input  logic [SYS_DAT-1:0]         sys_rdt,
    output logic                       lck_tmo
);

    localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int unsigned TMO_W = (LCK_TMO > 0) ? $clog2(LCK_TMO + 1) : 1;

    // One extra bit so ptr+offset can be reduced modulo REQ_NUM without wrap.
    localparam logic [PTR_W:0]   REQ_NUM_X = (PTR_W + 1)'(REQ_NUM);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(REQ_NUM - 1);

    // Elaboration-time parameter sanity checks.
    if (REQ_NUM < 1 || REQ_NUM > 8) begin : g_bad_req_num
        $error("tcb_peri_gpio_arb: REQ_NUM must be in 1..8");
    end
    if (SYS_ADR < 1) begin : g_bad_sys_adr
        $error("tcb_peri_gpio_arb: SYS_ADR must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   nxt_owner;

    logic [2*REQ_NUM-1:0] vld_dbl;
    logic [REQ_NUM-1:0]   vld_rot;
    logic [PTR_W-1:0]     off;
    logic                 fnd;
    logic [PTR_W:0]       sum;
    logic [PTR_W-1:0]     gnt;
    logic [PTR_W-1:0]     gnt_inc;
    logic                 gnt_vld;
    logic                 sel_wen;
    logic                 sel_lck;
    logic [REQ_NUM-1:0]   rdy_raw;
    logic                 tmo_hit;

    // Grant selection. In IDLE the valid vector is doubled and rotated right
    // by ptr, so the lowest set bit of the rotated vector is the first valid
    // requester at or after ptr; adding that offset back to ptr (mod REQ_NUM)
    // gives the granted index. In LOCK only the owner can be granted, whether
    // or not it is currently valid, so the address/data muxes follow it.
    always_comb begin
        vld_dbl = {req_vld, req_vld};
        vld_rot = REQ_NUM'(vld_dbl >> ptr);
        fnd     = 1'b0;
        off     = '0;
        for (int k = int'(REQ_NUM) - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                fnd = 1'b1;
                off = PTR_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= REQ_NUM_X) begin
            sum = sum - REQ_NUM_X;
        end
        if (state == LOCK) begin
            gnt     = owner;
            gnt_vld = req_vld[owner];
        end else begin
            gnt     = fnd ? sum[PTR_W-1:0] : '0;
            gnt_vld = fnd;
        end
    end

    // Fields of the granted requester and the rotation successor of the grant.
    // gnt_vld is the transfer itself: the grant only exists while that
    // requester is valid, and response state never stalls it.
    always_comb begin
        sel_wen = req_wen[gnt];
        sel_lck = req_lck[gnt];
        gnt_inc = (gnt == PTR_LAST) ? '0 : gnt + PTR_W'(1);
        rdy_raw = '0;
        if (gnt_vld) begin
            rdy_raw[gnt] = 1'b1;
        end
    end

    // Outputs to the requesters and the GPIO controller. Enables and grants
    // are forced low while reset is held so nothing reaches the controller
    // during reset; address and data simply follow the selected slice.
    always_comb begin
        req_rdy = rdy_raw & {REQ_NUM{~rst}};
        sys_wen = gnt_vld & sel_wen & ~rst;
        sys_ren = gnt_vld & ~sel_wen & ~rst;
        sys_wad = req_adr[int'(gnt)*SYS_ADR +: SYS_ADR];
        sys_rad = req_adr[int'(gnt)*SYS_ADR +: SYS_ADR];
        sys_wdt = req_wdt[int'(gnt)*SYS_DAT +: SYS_DAT];
    end

    // Lock timeout counter, only built when a timeout is configured. It counts
    // LOCK cycles without an owner transfer and fires when it has already
    // seen LCK_TMO-1 such cycles and the current cycle is idle too, so a lock
    // survives exactly LCK_TMO idle cycles.
    if (LCK_TMO > 0) begin : g_tmo
        localparam logic [TMO_W-1:0] TMO_END = TMO_W'(LCK_TMO - 1);
        logic [TMO_W-1:0] tmo_cnt;

        assign tmo_hit = (state == LOCK) & ~gnt_vld & (tmo_cnt == TMO_END);

        // Cleared outside LOCK, on every owner transfer and on release;
        // otherwise counts up and saturates.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tmo_cnt <= '0;
            end else if (state != LOCK || gnt_vld || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end else begin : g_no_tmo
        assign tmo_hit = 1'b0;
    end

    // Arbitration state machine, next-state half. A locking transfer in IDLE
    // takes ownership without moving ptr; any release (unlocking transfer or
    // timeout) moves ptr just past the releasing requester so the others get
    // the next turn.
    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_owner = owner;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    if (sel_lck) begin
                        nxt_state = LOCK;
                        nxt_owner = gnt;
                    end else begin
                        nxt_ptr = gnt_inc;
                    end
                end
            end
            LOCK: begin
                if (gnt_vld) begin
                    if (!sel_lck) begin
                        nxt_state = IDLE;
                        nxt_ptr   = gnt_inc;
                    end
                end else if (tmo_hit) begin
                    nxt_state = IDLE;
                    nxt_ptr   = gnt_inc;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Arbitration state machine, register half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= nxt_state;
            ptr   <= nxt_ptr;
            owner <= nxt_owner;
        end
    end

    // Registered response path. Every transfer answers on the next cycle on
    // its own rsp_vld bit; read data is captured from the controller, writes
    // leave the last read value in place. The timeout pulse is registered
    // alongside so it lines up with the first cycle back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= '0;
            rsp_rdt <= '0;
            lck_tmo <= 1'b0;
        end else begin
            rsp_vld <= rdy_raw;
            if (gnt_vld && !sel_wen) begin
                rsp_rdt <= sys_rdt;
            end
            lck_tmo <= tmo_hit;
        end
    end

endmodule

// File: tb/tb_tcb_peri_gpio_arb.sv
// ============================================================================
// tb_tcb_peri_gpio_arb
//
// Directed bench for tcb_peri_gpio_arb with two requesters and a lock timeout
// of four cycles. Each vector drives one cycle of requests, checks the
// combinational grant and GPIO strobes on the falling edge, and queues the
// hand-computed response it should produce. An independent monitor pops the
// queue on the cycle each response is due and otherwise insists rsp_vld is 0.
// ============================================================================
module tb_tcb_peri_gpio_arb;

    localparam int REQ_NUM = 2;
    localparam int SYS_DAT = 32;
    localparam int SYS_ADR = 3;
    localparam int LCK_TMO = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [REQ_NUM-1:0]         req_vld = '0;
    logic [REQ_NUM-1:0]         req_rdy;
    logic [REQ_NUM-1:0]         req_wen = '0;
    logic [REQ_NUM-1:0]         req_lck = '0;
    logic [REQ_NUM*SYS_ADR-1:0] req_adr = '0;
    logic [REQ_NUM*SYS_DAT-1:0] req_wdt = '0;
    logic [REQ_NUM-1:0]         rsp_vld;
    logic [SYS_DAT-1:0]         rsp_rdt;
    logic                       sys_wen;
    logic [SYS_ADR-1:0]         sys_wad;
    logic [SYS_DAT-1:0]         sys_wdt;
    logic                       sys_ren;
    logic [SYS_ADR-1:0]         sys_rad;
    logic [SYS_DAT-1:0]         sys_rdt = '0;
    logic                       lck_tmo;

    typedef struct {
        int          due;
        logic [1:0]  vld;
        logic [31:0] rdt;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec  = 0;
    int   n_mis  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    tcb_peri_gpio_arb #(
        .REQ_NUM(REQ_NUM),
        .SYS_DAT(SYS_DAT),
        .SYS_ADR(SYS_ADR),
        .LCK_TMO(LCK_TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_wen(req_wen),
        .req_lck(req_lck),
        .req_adr(req_adr),
        .req_wdt(req_wdt),
        .rsp_vld(rsp_vld),
        .rsp_rdt(rsp_rdt),
        .sys_wen(sys_wen),
        .sys_wad(sys_wad),
        .sys_wdt(sys_wdt),
        .sys_ren(sys_ren),
        .sys_rad(sys_rad),
        .sys_rdt(sys_rdt),
        .lck_tmo(lck_tmo)
    );

    // Free-running clock and a cycle counter used to time-stamp responses.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: on the cycle a queued response is due, compare it;
    // on every other cycle no response may appear.
    always @(negedge clk) begin
        rsp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                cmp("rsp_vld", 64'(rsp_vld), 64'(e.vld));
                cmp("rsp_rdt", 64'(rsp_rdt), 64'(e.rdt));
            end else begin
                cmp("rsp_quiet", 64'(rsp_vld), 64'(0));
            end
        end
    end

    // Drive one cycle of requests just after the rising edge and queue the
    // response expected on the following cycle (e_rsp == 0 means none).
    task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] wen,
                                 input logic [1:0] lck, input logic [2:0] a0,
                                 input logic [2:0] a1, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] rdt,
                                 input logic [1:0] e_rsp, input logic [31:0] e_rdt);
        rsp_t e;
        @(posedge clk);
        #1;
        req_vld = vld;
        req_wen = wen;
        req_lck = lck;
        req_adr = {a1, a0};
        req_wdt = {d1, d0};
        sys_rdt = rdt;
        if (e_rsp != 2'b00) begin
            e.due = cyc + 1;
            e.vld = e_rsp;
            e.rdt = e_rdt;
            exp_q.push_back(e);
        end
    endtask

    // Check the combinational grant and GPIO strobes on the falling edge.
    task automatic checkOutput(input string name, input logic [1:0] e_rdy,
                               input logic e_wen, input logic e_ren,
                               input logic [2:0] e_adr, input logic [31:0] e_wdt,
                               input logic e_tmo);
        @(negedge clk);
        cmp({name, ".rdy"}, 64'(req_rdy), 64'(e_rdy));
        cmp({name, ".en"}, 64'({sys_wen, sys_ren}), 64'({e_wen, e_ren}));
        cmp({name, ".tmo"}, 64'(lck_tmo), 64'(e_tmo));
        if (e_wen) begin
            cmp({name, ".wad"}, 64'(sys_wad), 64'(e_adr));
            cmp({name, ".wdt"}, 64'(sys_wdt), 64'(e_wdt));
        end
        if (e_ren) begin
            cmp({name, ".rad"}, 64'(sys_rad), 64'(e_adr));
        end
    endtask

    task automatic runVector(input string name, input logic [1:0] vld,
                             input logic [1:0] wen, input logic [1:0] lck,
                             input logic [2:0] a0, input logic [2:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] rdt, input logic [1:0] e_rsp,
                             input logic [31:0] e_rdt, input logic [1:0] e_rdy,
                             input logic e_wen, input logic e_ren,
                             input logic [2:0] e_adr, input logic [31:0] e_wdt,
                             input logic e_tmo);
        applyStimulus(vld, wen, lck, a0, a1, d0, d1, rdt, e_rsp, e_rdt);
        checkOutput(name, e_rdy, e_wen, e_ren, e_adr, e_wdt, e_tmo);
    endtask

    initial begin
        // Reset with both requesters already asking: nothing may be granted.
        #2 rst = 1'b1;
        #1 mon_en  = 1'b1;
        req_vld = 2'b11;
        req_wen = 2'b01;
        @(negedge clk);
        cmp("reset.rdy", 64'(req_rdy), 64'(0));
        cmp("reset.en", 64'({sys_wen, sys_ren}), 64'(0));
        cmp("reset.rsp_vld", 64'(rsp_vld), 64'(0));
        cmp("reset.rsp_rdt", 64'(rsp_rdt), 64'(0));
        cmp("reset.tmo", 64'(lck_tmo), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        req_vld = 2'b00;
        req_wen = 2'b00;

        //          name        vld    wen    lck    a0 a1  d0            d1            sys_rdt       rsp    rsp_rdt       rdy    wen   ren   adr  wdt           tmo
        // Single write from requester 0, then a read by requester 1.
        runVector("wr0",      2'b01, 2'b01, 2'b00, 1, 0, 32'h0000_00A5, 32'h0,        32'h0,        2'b01, 32'h0,        2'b01, 1'b1, 1'b0, 1, 32'h0000_00A5, 1'b0);
        runVector("rd1",      2'b10, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0000_1234, 2'b10, 32'h0000_1234, 2'b10, 1'b0, 1'b1, 0, 32'h0,        1'b0);
        runVector("idle",     2'b00, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);

        // Both valid: strict alternation, write responses keep the last read data.
        runVector("rr0",      2'b11, 2'b11, 2'b00, 2, 3, 32'h11,       32'h22,       32'h0,        2'b01, 32'h0000_1234, 2'b01, 1'b1, 1'b0, 2, 32'h11,       1'b0);
        runVector("rr1",      2'b11, 2'b11, 2'b00, 2, 3, 32'h11,       32'h22,       32'h0,        2'b10, 32'h0000_1234, 2'b10, 1'b1, 1'b0, 3, 32'h22,       1'b0);
        runVector("rr2",      2'b11, 2'b11, 2'b00, 2, 3, 32'h11,       32'h22,       32'h0,        2'b01, 32'h0000_1234, 2'b01, 1'b1, 1'b0, 2, 32'h11,       1'b0);
        runVector("rr3",      2'b11, 2'b11, 2'b00, 2, 3, 32'h11,       32'h22,       32'h0,        2'b10, 32'h0000_1234, 2'b10, 1'b1, 1'b0, 3, 32'h22,       1'b0);

        // Locked read-modify-write by requester 0 while requester 1 waits.
        runVector("lk_rd",    2'b11, 2'b10, 2'b01, 5, 6, 32'h0,        32'h66,       32'h0000_CAFE, 2'b01, 32'h0000_CAFE, 2'b01, 1'b0, 1'b1, 5, 32'h0,        1'b0);
        runVector("lk_hold",  2'b10, 2'b10, 2'b00, 5, 6, 32'h0,        32'h66,       32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("lk_wr",    2'b11, 2'b11, 2'b00, 5, 6, 32'h0000_CAFF, 32'h66,       32'h0,        2'b01, 32'h0000_CAFE, 2'b01, 1'b1, 1'b0, 5, 32'h0000_CAFF, 1'b0);
        runVector("lk_next",  2'b11, 2'b11, 2'b00, 5, 6, 32'h0000_CAFF, 32'h66,       32'h0,        2'b10, 32'h0000_CAFE, 2'b10, 1'b1, 1'b0, 6, 32'h66,       1'b0);
        runVector("idle2",    2'b00, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);

        // Requester 0 locks and goes silent: four idle lock cycles, then the
        // timeout pulse coincides with requester 1 being granted.
        runVector("to_lock",  2'b01, 2'b00, 2'b01, 4, 7, 32'h0,        32'h0,        32'h77,       2'b01, 32'h77,       2'b01, 1'b0, 1'b1, 4, 32'h0,        1'b0);
        runVector("to_wait1", 2'b10, 2'b00, 2'b00, 4, 7, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("to_wait2", 2'b10, 2'b00, 2'b00, 4, 7, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("to_wait3", 2'b10, 2'b00, 2'b00, 4, 7, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("to_wait4", 2'b10, 2'b00, 2'b00, 4, 7, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("to_pulse", 2'b10, 2'b00, 2'b00, 4, 7, 32'h0,        32'h0,        32'h88,       2'b10, 32'h88,       2'b10, 1'b0, 1'b1, 7, 32'h0,        1'b1);
        runVector("to_after", 2'b00, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);

        // Reset in the middle of a lock with a read response in flight.
        runVector("rs_lock",  2'b11, 2'b10, 2'b01, 2, 1, 32'h0,        32'h44,       32'h99,       2'b01, 32'h99,       2'b01, 1'b0, 1'b1, 2, 32'h0,        1'b0);
        runVector("rs_pend",  2'b11, 2'b10, 2'b01, 3, 1, 32'h0,        32'h44,       32'h0000_00AB, 2'b00, 32'h0,        2'b01, 1'b0, 1'b1, 3, 32'h0,        1'b0);
        #1 rst = 1'b1;
        #1;
        cmp("rs_now.rsp_vld", 64'(rsp_vld), 64'(0));
        cmp("rs_now.rsp_rdt", 64'(rsp_rdt), 64'(0));
        cmp("rs_now.rdy", 64'(req_rdy), 64'(0));
        cmp("rs_now.en", 64'({sys_wen, sys_ren}), 64'(0));
        cmp("rs_now.tmo", 64'(lck_tmo), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        req_vld = 2'b00;
        req_wen = 2'b00;
        req_lck = 2'b00;
        runVector("rs_after", 2'b10, 2'b00, 2'b00, 0, 1, 32'h0,        32'h0,        32'h0000_005A, 2'b10, 32'h0000_005A, 2'b10, 1'b0, 1'b1, 1, 32'h0,        1'b0);
        runVector("rs_idle",  2'b00, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);
        runVector("rs_idle2", 2'b00, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 1'b0, 1'b0, 0, 32'h0,        1'b0);

        // Every queued response must have been consumed by now.
        cmp("rsp_drained", 64'(exp_q.size()), 64'(0));
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
